// File: rtl/synapse_mac.sv
// Synaptic integration stage: walks a latched spike vector one synapse per cycle,
// accumulates signed weights and emits a clamped sum as a single-cycle pulse.
module synapse_mac #(
    parameter int N_INPUTS   = 16,
    parameter int DATA_WIDTH = 8,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int MAX_VAL    = 100,
    localparam int AW        = $clog2(N_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_INPUTS-1:0]   in_spikes,
    input  logic                  w_we,
    input  logic [AW-1:0]         w_addr,
    input  logic [W_WIDTH-1:0]    w_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_mac_sum
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic [AW-1:0]               LAST_IDX = AW'(N_INPUTS - 1);
    localparam logic [AW:0]                 N_EXT    = (AW + 1)'(N_INPUTS);
    localparam logic signed [ACC_WIDTH-1:0] MAX_ACC  = ACC_WIDTH'(MAX_VAL);
    localparam logic [DATA_WIDTH-1:0]       MAX_OUT  = DATA_WIDTH'(MAX_VAL);

    state_t                      state_r;
    state_t                      state_s;
    logic signed [W_WIDTH-1:0]   weight_r [N_INPUTS];
    logic [N_INPUTS-1:0]         spk_r;
    logic [AW-1:0]               idx_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] term_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic                        last_s;
    logic                        w_addr_ok_s;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic [DATA_WIDTH-1:0]       out_mac_sum_r;

    function automatic logic signed [ACC_WIDTH-1:0] sign_ext(input logic signed [W_WIDTH-1:0] w);
        return {{(ACC_WIDTH - W_WIDTH){w[W_WIDTH-1]}}, w};
    endfunction

    // Negative sums floor at zero, anything above MAX_VAL saturates.
    function automatic logic [DATA_WIDTH-1:0] clamp_sum(input logic signed [ACC_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v[ACC_WIDTH-1]) begin
            r = {DATA_WIDTH{1'b0}};
        end else if (v > MAX_ACC) begin
            r = MAX_OUT;
        end else begin
            r = v[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    // Current synapse term, final-sum formation and write-address range check.
    always_comb begin
        term_s      = {ACC_WIDTH{1'b0}};
        w_addr_ok_s = ({1'b0, w_addr} < N_EXT);
        last_s      = (idx_r == LAST_IDX);
        if (spk_r[idx_r]) begin
            term_s = sign_ext(weight_r[idx_r]);
        end else begin
            term_s = {ACC_WIDTH{1'b0}};
        end
        sum_s = acc_r + term_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_s = S_ACCUM;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (last_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_ACCUM;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Weight memory; reads this cycle see the value before any same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_r[i] <= {W_WIDTH{1'b0}};
            end
        end else if (w_we && w_addr_ok_s) begin
            weight_r[w_addr] <= w_data;
        end
    end

    // Datapath and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spk_r         <= {N_INPUTS{1'b0}};
            idx_r         <= {AW{1'b0}};
            acc_r         <= {ACC_WIDTH{1'b0}};
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_mac_sum_r <= {DATA_WIDTH{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            in_ready_r  <= (state_s == S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        spk_r <= in_spikes;
                        acc_r <= {ACC_WIDTH{1'b0}};
                        idx_r <= {AW{1'b0}};
                    end
                end
                S_ACCUM: begin
                    acc_r <= sum_s;
                    if (last_s) begin
                        idx_r         <= {AW{1'b0}};
                        out_mac_sum_r <= clamp_sum(sum_s);
                        out_valid_r   <= 1'b1;
                    end else begin
                        idx_r <= idx_r + AW'(1);
                    end
                end
                default: begin
                    idx_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_mac_sum = out_mac_sum_r;

endmodule
